// File: rtl/rv32i_types.sv
// Shared rv32i types: default core geometry constants and the rename-table entry.
package rv32i_types;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_REGF_SIZE  = 32;
  localparam int unsigned DEF_ROB_LENGTH = 16;
  localparam int unsigned DEF_NUM_RD     = 4;
  localparam int unsigned DEF_DEC_W      = 2;
  localparam int unsigned DEF_CMT_W      = 2;
  localparam int unsigned RAT_TW         = $clog2(DEF_ROB_LENGTH);

  typedef struct packed {
    logic [RAT_TW-1:0] tag;
    logic              busy;
  } rat_entry_t;

endpackage

// File: rtl/regfile_rat_if.sv
// Read, rename and commit bus of the register file / register alias table.
interface regfile_rat_if #(
  parameter int unsigned DATA_WIDTH = rv32i_types::DEF_DATA_WIDTH,
  parameter int unsigned REGF_SIZE  = rv32i_types::DEF_REGF_SIZE,
  parameter int unsigned ROB_LENGTH = rv32i_types::DEF_ROB_LENGTH,
  parameter int unsigned NUM_RD     = rv32i_types::DEF_NUM_RD,
  parameter int unsigned DEC_W      = rv32i_types::DEF_DEC_W,
  parameter int unsigned CMT_W      = rv32i_types::DEF_CMT_W
);
  localparam int unsigned AW = $clog2(REGF_SIZE);
  localparam int unsigned TW = $clog2(ROB_LENGTH);

  logic [AW-1:0]         rs_addr  [NUM_RD];
  logic [DATA_WIDTH-1:0] rs_data  [NUM_RD];
  logic [TW-1:0]         rs_tag   [NUM_RD];
  logic                  rs_busy  [NUM_RD];
  logic                  dec_we   [DEC_W];
  logic [AW-1:0]         dec_rd   [DEC_W];
  logic [TW-1:0]         dec_rob  [DEC_W];
  logic                  cmt_we   [CMT_W];
  logic [AW-1:0]         cmt_rd   [CMT_W];
  logic [DATA_WIDTH-1:0] cmt_data [CMT_W];
  logic [TW-1:0]         cmt_rob  [CMT_W];
  logic                  flush;

  modport master (
    output rs_addr, dec_we, dec_rd, dec_rob, cmt_we, cmt_rd, cmt_data, cmt_rob, flush,
    input  rs_data, rs_tag, rs_busy
  );

  modport slave (
    input  rs_addr, dec_we, dec_rd, dec_rob, cmt_we, cmt_rd, cmt_data, cmt_rob, flush,
    output rs_data, rs_tag, rs_busy
  );

endinterface

// File: rtl/regfile_rat_merge.sv
// Next-state merge for one register entry: picks the youngest decode and commit
// hitting REG_IDX and applies decode-over-commit priority and flush.
module regfile_rat_merge
  import rv32i_types::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned REGF_SIZE  = DEF_REGF_SIZE,
  parameter int unsigned ROB_LENGTH = DEF_ROB_LENGTH,
  parameter int unsigned DEC_W      = DEF_DEC_W,
  parameter int unsigned CMT_W      = DEF_CMT_W,
  parameter int unsigned REG_IDX    = 0,
  localparam int unsigned AW        = $clog2(REGF_SIZE),
  localparam int unsigned TW        = $clog2(ROB_LENGTH)
) (
  input  logic [DATA_WIDTH-1:0] cur_data,
  input  rat_entry_t            cur_ent,
  input  logic                  dec_we   [DEC_W],
  input  logic [AW-1:0]         dec_rd   [DEC_W],
  input  logic [TW-1:0]         dec_rob  [DEC_W],
  input  logic                  cmt_we   [CMT_W],
  input  logic [AW-1:0]         cmt_rd   [CMT_W],
  input  logic [DATA_WIDTH-1:0] cmt_data [CMT_W],
  input  logic [TW-1:0]         cmt_rob  [CMT_W],
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] nxt_data,
  output rat_entry_t            nxt_ent
);

  logic                  dec_hit;
  logic [TW-1:0]         dec_tag;
  logic                  cmt_hit;
  logic [TW-1:0]         cmt_tag;
  logic [DATA_WIDTH-1:0] cmt_val;

  // Later ports overwrite earlier ones, so the highest matching index wins.
  always_comb begin
    dec_hit  = 1'b0;
    dec_tag  = '0;
    cmt_hit  = 1'b0;
    cmt_tag  = '0;
    cmt_val  = '0;
    nxt_data = cur_data;
    nxt_ent  = cur_ent;

    for (int j = 0; j < int'(DEC_W); j++) begin
      if (dec_we[j] && (dec_rd[j] == AW'(REG_IDX))) begin
        dec_hit = 1'b1;
        dec_tag = dec_rob[j];
      end
    end
    for (int k = 0; k < int'(CMT_W); k++) begin
      if (cmt_we[k] && (cmt_rd[k] == AW'(REG_IDX))) begin
        cmt_hit = 1'b1;
        cmt_tag = cmt_rob[k];
        cmt_val = cmt_data[k];
      end
    end

    // Data always lands; busy only drops if the committing tag is still the latest writer.
    if (cmt_hit) begin
      nxt_data = cmt_val;
      if (cur_ent.tag == RAT_TW'(cmt_tag)) nxt_ent.busy = 1'b0;
    end

    if (flush) begin
      nxt_ent.busy = 1'b0;
    end else if (dec_hit) begin
      nxt_ent.tag  = RAT_TW'(dec_tag);
      nxt_ent.busy = 1'b1;
    end

    if (REG_IDX == 0) begin
      nxt_data = '0;
      nxt_ent  = '0;
    end
  end

endmodule

// File: rtl/regfile_rat.sv
// Architectural register file fused with the rename alias table (data, ROB tag, busy).
// Define REGF_BYPASS_EN to forward same-cycle commits onto the read ports.
module regfile_rat
  import rv32i_types::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned REGF_SIZE  = DEF_REGF_SIZE,
  parameter int unsigned ROB_LENGTH = DEF_ROB_LENGTH,
  parameter int unsigned NUM_RD     = DEF_NUM_RD,
  parameter int unsigned DEC_W      = DEF_DEC_W,
  parameter int unsigned CMT_W      = DEF_CMT_W,
  localparam int unsigned AW        = $clog2(REGF_SIZE),
  localparam int unsigned TW        = $clog2(ROB_LENGTH)
) (
  input  logic          clk,
  input  logic          rst,
  regfile_rat_if.slave  bus
);

  logic [DATA_WIDTH-1:0] data_q [REGF_SIZE];
  rat_entry_t            ent_q  [REGF_SIZE];
  logic [DATA_WIDTH-1:0] data_d [REGF_SIZE];
  rat_entry_t            ent_d  [REGF_SIZE];

  for (genvar r = 0; r < int'(REGF_SIZE); r++) begin : g_reg
    regfile_rat_merge #(
      .DATA_WIDTH (DATA_WIDTH),
      .REGF_SIZE  (REGF_SIZE),
      .ROB_LENGTH (ROB_LENGTH),
      .DEC_W      (DEC_W),
      .CMT_W      (CMT_W),
      .REG_IDX    (r)
    ) u_merge (
      .cur_data (data_q[r]),
      .cur_ent  (ent_q[r]),
      .dec_we   (bus.dec_we),
      .dec_rd   (bus.dec_rd),
      .dec_rob  (bus.dec_rob),
      .cmt_we   (bus.cmt_we),
      .cmt_rd   (bus.cmt_rd),
      .cmt_data (bus.cmt_data),
      .cmt_rob  (bus.cmt_rob),
      .flush    (bus.flush),
      .nxt_data (data_d[r]),
      .nxt_ent  (ent_d[r])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < int'(REGF_SIZE); r++) begin
        data_q[r] <= '0;
        ent_q[r]  <= '0;
      end
    end else begin
      for (int r = 0; r < int'(REGF_SIZE); r++) begin
        data_q[r] <= data_d[r];
        ent_q[r]  <= ent_d[r];
      end
    end
  end

  for (genvar p = 0; p < int'(NUM_RD); p++) begin : g_rd
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_busy;
    rat_entry_t            rd_ent;

    assign rd_ent = ent_q[bus.rs_addr[p]];

`ifdef REGF_BYPASS_EN
    logic                  byp_hit;
    logic [DATA_WIDTH-1:0] byp_data;
    logic [TW-1:0]         byp_tag;
    logic                  dec_pend;

    // Youngest matching commit is forwarded; x0 never matches.
    always_comb begin
      byp_hit  = 1'b0;
      byp_data = '0;
      byp_tag  = '0;
      dec_pend = 1'b0;
      for (int k = 0; k < int'(CMT_W); k++) begin
        if (bus.cmt_we[k] && (bus.cmt_rd[k] == bus.rs_addr[p]) && (bus.rs_addr[p] != '0)) begin
          byp_hit  = 1'b1;
          byp_data = bus.cmt_data[k];
          byp_tag  = bus.cmt_rob[k];
        end
      end
      for (int j = 0; j < int'(DEC_W); j++) begin
        if (bus.dec_we[j] && (bus.dec_rd[j] == bus.rs_addr[p])) dec_pend = 1'b1;
      end
      rd_data = byp_hit ? byp_data : data_q[bus.rs_addr[p]];
      rd_busy = rd_ent.busy &&
                !(byp_hit && (RAT_TW'(byp_tag) == rd_ent.tag) && !dec_pend);
    end
`else
    assign rd_data = data_q[bus.rs_addr[p]];
    assign rd_busy = rd_ent.busy;
`endif

    assign bus.rs_data[p] = rd_data;
    assign bus.rs_tag[p]  = TW'(rd_ent.tag);
    assign bus.rs_busy[p] = rd_busy;
  end

endmodule

// File: tb/tb_regfile_rat.sv
// Directed scoreboard bench for regfile_rat: stimulus queues expected reads,
// a monitor compares them when the read strobe is presented.
`timescale 1ns/1ps
module tb_regfile_rat;
  import rv32i_types::*;

  typedef struct {
    int          port;
    logic [31:0] data;
    logic [3:0]  tag;
    logic        busy;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic chk_valid = 1'b0;
  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   rd_port = 0;

  always #5 clk = ~clk;

  regfile_rat_if bus ();

  regfile_rat dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic idle();
    for (int j = 0; j < 2; j++) begin
      bus.dec_we[j]   = 1'b0;
      bus.dec_rd[j]   = '0;
      bus.dec_rob[j]  = '0;
      bus.cmt_we[j]   = 1'b0;
      bus.cmt_rd[j]   = '0;
      bus.cmt_data[j] = '0;
      bus.cmt_rob[j]  = '0;
    end
    bus.flush = 1'b0;
    rst       = 1'b0;
  endtask

  task automatic dec(input int port, input int rd, input int tag);
    bus.dec_we[port]  = 1'b1;
    bus.dec_rd[port]  = 5'(rd);
    bus.dec_rob[port] = 4'(tag);
  endtask

  task automatic cmt(input int port, input int rd, input int tag, input logic [31:0] d);
    bus.cmt_we[port]   = 1'b1;
    bus.cmt_rd[port]   = 5'(rd);
    bus.cmt_rob[port]  = 4'(tag);
    bus.cmt_data[port] = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic check(input int r, input logic [31:0] d, input logic [3:0] t,
                       input logic b, input string nm);
    exp_t e;
    e.port = rd_port;
    e.data = d;
    e.tag  = t;
    e.busy = b;
    e.name = nm;
    bus.rs_addr[rd_port] = 5'(r);
    sb.push_back(e);
    chk_valid = 1'b1;
    #1;
    chk_valid = 1'b0;
    #1;
    rd_port = (rd_port + 1) % 4;
  endtask

  // Monitor: read outputs are settled by the falling edge of the strobe.
  initial begin
    exp_t e;
    forever begin
      @(negedge chk_valid);
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL monitor: read strobe with empty scoreboard");
      end else begin
        e = sb.pop_front();
        if (bus.rs_data[e.port] !== e.data || bus.rs_tag[e.port] !== e.tag ||
            bus.rs_busy[e.port] !== e.busy) begin
          bad++;
          $display("FAIL %s: got data=%h tag=%0d busy=%b, want data=%h tag=%0d busy=%b",
                   e.name, bus.rs_data[e.port], bus.rs_tag[e.port], bus.rs_busy[e.port],
                   e.data, e.tag, e.busy);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    for (int p = 0; p < 4; p++) bus.rs_addr[p] = '0;
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    idle();

    check(0,  32'h0, 4'd0, 1'b0, "reset_x0");
    check(5,  32'h0, 4'd0, 1'b0, "reset_x5");
    check(31, 32'h0, 4'd0, 1'b0, "reset_x31");

    // Rename then commit
    @(negedge clk); dec(0, 5, 3); step();
    check(5, 32'h0, 4'd3, 1'b1, "rename_x5");
    @(negedge clk); cmt(0, 5, 3, 32'hDEAD_BEEF); step();
    check(5, 32'hDEAD_BEEF, 4'd3, 1'b0, "commit_x5");

    // Stale commit leaves the younger rename busy
    @(negedge clk); dec(0, 7, 2); step();
    @(negedge clk); dec(1, 7, 9); step();
    @(negedge clk); cmt(0, 7, 2, 32'h11); step();
    check(7, 32'h11, 4'd9, 1'b1, "stale_commit_x7");

    // Same-cycle decode/decode/commit conflict
    @(negedge clk); dec(0, 4, 1); dec(1, 4, 6); cmt(0, 4, 1, 32'h22); step();
    check(4, 32'h22, 4'd6, 1'b1, "conflict_x4");

    // Commit port priority
    @(negedge clk); dec(0, 8, 5); dec(1, 10, 7); step();
    @(negedge clk); cmt(0, 8, 0, 32'hA); cmt(1, 8, 5, 32'hB); step();
    check(8, 32'hB, 4'd5, 1'b0, "cmt_prio_x8");
    @(negedge clk); cmt(0, 10, 7, 32'h1); cmt(1, 10, 2, 32'h2); step();
    check(10, 32'h2, 4'd7, 1'b1, "cmt_prio_x10");

    // Flush
    @(negedge clk); dec(0, 1, 1); dec(1, 2, 2); step();
    @(negedge clk); dec(0, 3, 3); step();
    check(1, 32'h0, 4'd1, 1'b1, "preflush_x1");
    @(negedge clk); bus.flush = 1'b1; cmt(0, 2, 2, 32'h55); dec(0, 9, 4); step();
    check(1,  32'h0,  4'd1, 1'b0, "flush_x1");
    check(2,  32'h55, 4'd2, 1'b0, "flush_x2");
    check(3,  32'h0,  4'd3, 1'b0, "flush_x3");
    check(9,  32'h0,  4'd0, 1'b0, "flush_x9");
    check(7,  32'h11, 4'd9, 1'b0, "flush_x7");
    check(4,  32'h22, 4'd6, 1'b0, "flush_x4");
    check(10, 32'h2,  4'd7, 1'b0, "flush_x10");

    // x0 ignores writes
    @(negedge clk); dec(0, 0, 5); cmt(0, 0, 5, 32'hFF); step();
    check(0, 32'h0, 4'd0, 1'b0, "x0_write");

    // Same-cycle decode not visible on reads
    @(negedge clk); dec(1, 12, 3);
    check(12, 32'h0, 4'd0, 1'b0, "dec_same_cycle_x12");
    step();
    check(12, 32'h0, 4'd3, 1'b1, "dec_after_x12");

    // Same-cycle commit read
    @(negedge clk); dec(0, 6, 4); step();
    @(negedge clk); cmt(1, 6, 4, 32'h77);
`ifdef REGF_BYPASS_EN
    check(6, 32'h77, 4'd4, 1'b0, "bypass_x6");
`else
    check(6, 32'h0,  4'd4, 1'b1, "nobypass_x6");
`endif
    step();
    check(6, 32'h77, 4'd4, 1'b0, "commit_x6");

    // Reset mid-burst
    @(negedge clk); dec(0, 13, 1); cmt(0, 2, 2, 32'h99); rst = 1'b1; step();
    check(2,  32'h0, 4'd0, 1'b0, "rst_x2");
    check(13, 32'h0, 4'd0, 1'b0, "rst_x13");
    check(7,  32'h0, 4'd0, 1'b0, "rst_x7");
    check(5,  32'h0, 4'd0, 1'b0, "rst_x5");
    check(12, 32'h0, 4'd0, 1'b0, "rst_x12");

    repeat (2) @(posedge clk);
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_rat.md
REGFILE_RAT -- requirements
Module: regfile_rat

Interface
REQ-001 The block SHALL take these parameters, one per line: name, default, meaning.
- DATA_WIDTH, 32, register data width.
- REGF_SIZE, 32, architectural register count.
- ROB_LENGTH, 16, ROB entries.
- NUM_RD, 4, read ports.
- DEC_W, 2, rename (decode) ports.
- CMT_W, 2, commit ports.
- AW and TW are derived: clog2(REGF_SIZE) and clog2(ROB_LENGTH).

REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk, in, 1, clock.
- rst, in, 1, synchronous active-high reset.
- rs_addr[NUM_RD], in, AW, read addresses.
- rs_data[NUM_RD], out, DATA_WIDTH, register value.
- rs_tag[NUM_RD], out, TW, pending ROB tag.
- rs_busy[NUM_RD], out, 1, pending-writer flag.
- dec_we[DEC_W], in, 1, rename request.
- dec_rd[DEC_W], in, AW, destination.
- dec_rob[DEC_W], in, TW, allocated ROB tag.
- cmt_we[CMT_W], in, 1, commit write.
- cmt_rd[CMT_W], in, AW, destination.
- cmt_data[CMT_W], in, DATA_WIDTH, value.
- cmt_rob[CMT_W], in, TW, committing tag.
- flush, in, 1, branch-mispredict flush.

Function
REQ-003 Each register entry SHALL hold data, tag and busy; reads SHALL be combinational with zero latency.
REQ-004 Register 0 SHALL always read data 0 and busy 0, and SHALL ignore all decode and commit writes.
REQ-005 A commit on port k SHALL write cmt_data into data[cmt_rd] at the next clk edge.
REQ-006 That commit SHALL clear busy only if the stored tag equals cmt_rob.
REQ-007 When several commit ports target one register in a cycle, the highest port index SHALL win (it is youngest), for data and for the tag match.
REQ-008 A decode on port j SHALL set tag to dec_rob and busy to 1 at the next edge.
REQ-009 When several decode ports target one register, the highest index SHALL win.
REQ-010 When a decode and a commit hit the same register in one cycle, the decode SHALL win tag and busy, and the commit SHALL still write data.
REQ-011 During flush, all busy bits SHALL clear at the next edge, decode requests SHALL be ignored, commit data writes SHALL still apply, and tags SHALL hold.
REQ-012 Read ports SHALL NOT reflect same-cycle decode writes; intra-group dependencies are resolved by the decoder.
REQ-013 The block SHALL keep no state other than the per-register entries, so its latency is one edge for every update.

Reset
REQ-014 On rst, all data, tag and busy bits SHALL clear to 0 at the next edge.
REQ-015 rst SHALL override flush, decode and commit.
REQ-016 When rst is asserted mid-burst, the block SHALL discard all in-flight requests of that cycle.

Configuration
REQ-017 With REGF_BYPASS_EN defined, each read port SHALL forward same-cycle commit data (highest matching commit port).
REQ-018 With REGF_BYPASS_EN defined, rs_busy SHALL read 0 when that commit's tag matches the stored tag and no flush-independent decode to the register is pending.
REQ-019 Without REGF_BYPASS_EN, reads SHALL show only registered state.

Structure
REQ-020 The rat_entry_t struct (tag, busy) and the default parameter constants SHALL live in the shared rv32i_types package.
REQ-021 Per-register next-state priority (decode/commit merge) SHALL be one sub-module, regfile_rat_merge, instantiated once per register.

Verification
REQ-022 Rename then commit: dec x5 tag 3, then cmt x5 tag 3 data 0xDEAD_BEEF -> x5 busy 1, tag 3 after the first edge; data 0xDEADBEEF, busy 0 after the second.
REQ-023 Stale commit: dec x7 tag 2, dec x7 tag 9, cmt x7 tag 2 data 0x11 -> x7 data 0x11, busy 1, tag 9.
REQ-024 Same-cycle conflicts: dec port0 x4 tag 1 and port1 x4 tag 6, plus cmt x4 tag 1 data 0x22 -> tag 6, busy 1, data 0x22.
REQ-025 Flush: x1, x2, x3 busy; flush together with cmt x2 data 0x55 and dec x9 -> all busy 0, x2 data 0x55, x9 unchanged.
REQ-026 x0 and bypass: dec x0 and cmt x0 data 0xFF -> x0 reads 0. With REGF_BYPASS_EN, cmt x6 tag 4 data 0x77 while x6 tag 4 -> rs_data 0x77, rs_busy 0 in the same cycle.
REQ-027 Reset mid-burst: rst asserted with decode and commit active -> all entries read 0 after the edge.
